// File: rtl/zap_cdc_handshake_tx.sv
// zap_cdc_handshake_tx: source end of a two-phase toggle req/ack clock-domain-crossing channel
module zap_cdc_handshake_tx #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_req,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ack,
    output logic             o_done,
    output logic             o_timeout,
    output logic             o_spurious_ack
);
    localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t           state_q, state_d;
    logic             ack_meta_q, ack_sync_q;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             spur_q, spur_d;

    // two-flop synchronizer for the asynchronous ack toggle
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= i_ack;
            ack_sync_q <= ack_meta_q;
        end
    end

    // next state: accept in IDLE, wait for matching ack toggle, track timeout and stray acks
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        spur_d    = spur_q;
        if (state_q == IDLE) begin
            if (ack_sync_q != req_q) spur_d = 1'b1;
            if (i_valid) begin
                state_d = WAIT_ACK;
                req_d   = ~req_q;
                data_d  = i_data;
                cnt_d   = '0;
            end
        end else if (ack_sync_q == req_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end else begin
            if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
            if (TIMEOUT_CYCLES != 0 && 32'(cnt_q) == TIMEOUT_CYCLES - 1) timeout_d = 1'b1;
        end
    end

    // state and output registers
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            data_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            spur_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            spur_q    <= spur_d;
        end
    end

    assign o_ready        = (state_q == IDLE);
    assign o_req          = req_q;
    assign o_data         = data_q;
    assign o_done         = done_q;
    assign o_timeout      = timeout_q;
    assign o_spurious_ack = spur_q;
endmodule

// File: tb/tb_zap_cdc_handshake_tx.sv
// tb_zap_cdc_handshake_tx: directed bench with a cycle model for the toggle-handshake transmitter
module tb_zap_cdc_handshake_tx;
    localparam int W  = 32;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic [W-1:0] data;
    logic         ack;
    logic         ready, req, done, tout, spur;
    logic [W-1:0] odata;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    zap_cdc_handshake_tx #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_data(data),
        .o_ready(ready), .o_req(req), .o_data(odata), .i_ack(ack),
        .o_done(done), .o_timeout(tout), .o_spurious_ack(spur)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the block sees i_ack two edges late; busy from accept until that delayed ack
    // equals the current request parity; timeout after TO unanswered busy edges.
    logic         m_live = 1'b0;
    logic         m_busy, m_req, m_done, m_to, m_spur;
    logic [W-1:0] m_data;
    logic [1:0]   ack_hist;
    int           m_wait;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_live <= 1'b1; m_busy <= 1'b0; m_req <= 1'b0; m_data <= '0; m_done <= 1'b0;
            m_to <= 1'b0; m_spur <= 1'b0; m_wait <= 0; ack_hist <= 2'b00;
        end else begin
            m_done   <= 1'b0;
            ack_hist <= {ack_hist[0], ack};
            if (!m_busy) begin
                if (ack_hist[1] != m_req) m_spur <= 1'b1;
                if (valid) begin
                    m_busy <= 1'b1; m_req <= ~m_req; m_data <= data; m_wait <= 0;
                end
            end else if (ack_hist[1] == m_req) begin
                m_busy <= 1'b0; m_done <= 1'b1;
            end else begin
                m_wait <= m_wait + 1;
                if (m_wait + 1 >= TO) m_to <= 1'b1;
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_live) begin
            chk("m_ready", W'(ready), W'(!m_busy));
            chk("m_req", W'(req), W'(m_req));
            chk("m_data", odata, m_data);
            chk("m_done", W'(done), W'(m_done));
            chk("m_timeout", W'(tout), W'(m_to));
            chk("m_spurious", W'(spur), W'(m_spur));
            if (done === 1'b1) n_done++;
        end
    end

    task automatic edge1;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin edge1(); n++; end while (done !== 1'b1 && n < 40);
        if (done !== 1'b1) begin
            errors++; checks++;
            $display("FAIL done_wait: o_done never pulsed within %0d edges", n);
        end
    endtask

    int n, d0;
    logic prev;

    initial begin
        rst_n = 1'b0; valid = 1'b1; data = 32'hDEADBEEF; ack = 1'b0;
        repeat (3) edge1();
        chk("rst_req", W'(req), 0);
        chk("rst_data", odata, 0);
        chk("rst_ready", W'(ready), 1);
        chk("rst_done", W'(done), 0);
        rst_n = 1'b1;
        edge1();
        chk("acc_req", W'(req), 1);
        chk("acc_data", odata, 32'hDEADBEEF);
        chk("acc_ready", W'(ready), 0);
        data = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            edge1();
            chk("busy_data", odata, 32'hDEADBEEF);
            chk("busy_req", W'(req), 1);
        end
        ack = 1'b1;
        wait_done(n);
        chk("busy_done_lat", n, 3);
        chk("busy_done_ready", W'(ready), 1);
        edge1();
        chk("b2b_accept_data", odata, 32'h12345678);
        chk("b2b_accept_req", W'(req), 0);
        chk("b2b_done_low", W'(done), 0);
        valid = 1'b0;
        edge1();
        ack = 1'b0;
        wait_done(n);
        chk("single_done_lat", n, 3);
        edge1();
        chk("single_done_pulse", W'(done), 0);

        d0 = n_done;
        valid = 1'b1; data = 0;
        for (int i = 0; i < 8; i++) begin
            prev = req; n = 0;
            do begin edge1(); n++; end while (req === prev && n < 20);
            chk("seq_data", odata, W'(i));
            chk("seq_gap", n, (i == 0) ? 1 : 4);
            ack = ~ack;
            data = W'(i + 1);
            valid = (i < 7);
        end
        wait_done(n);
        edge1();
        chk("seq_done_count", n_done - d0, 8);
        chk("seq_req", W'(req), 0);

        valid = 1'b1; data = 32'hA0A00001;
        edge1();
        valid = 1'b0;
        repeat (15) edge1();
        chk("to_before", W'(tout), 0);
        edge1();
        chk("to_set", W'(tout), 1);
        chk("to_ready", W'(ready), 0);
        repeat (5) edge1();
        chk("to_stay", W'(ready), 0);
        ack = 1'b1;
        wait_done(n);
        chk("to_done_lat", n, 3);
        chk("to_sticky", W'(tout), 1);

        edge1();
        ack = 1'b0;
        repeat (2) edge1();
        chk("spur_before", W'(spur), 0);
        edge1();
        chk("spur_set", W'(spur), 1);
        chk("spur_ready", W'(ready), 1);
        chk("spur_req", W'(req), 1);
        ack = 1'b1;
        repeat (4) edge1();
        valid = 1'b1; data = 32'h55AA55AA;
        edge1();
        valid = 1'b0;
        chk("mid_req", W'(req), 0);
        chk("mid_ready", W'(ready), 0);
        repeat (3) edge1();
        rst_n = 1'b0; ack = 1'b0;
        edge1();
        chk("mrst_req", W'(req), 0);
        chk("mrst_ready", W'(ready), 1);
        chk("mrst_data", odata, 0);
        chk("mrst_to", W'(tout), 0);
        chk("mrst_spur", W'(spur), 0);
        rst_n = 1'b1;
        repeat (5) edge1();
        chk("post_spur", W'(spur), 0);
        chk("post_ready", W'(ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/zap_cdc_handshake_tx.md
# zap_cdc_handshake_tx

Source-domain end of a two-phase (toggle) request/acknowledge clock-domain-crossing channel. Accepts a WIDTH-bit word from local logic over a valid/ready interface, holds it stable on `o_data`, toggles `o_req` towards the destination domain, and waits for the destination's toggled `i_ack`. `i_ack` passes through an internal two-flop synchronizer before use. The block pairs with a destination-side receiver that samples `o_req` through a dual-rank synchronizer.

## Interface
- `WIDTH`, 32'd32, payload width in bits (≥1).
- `TIMEOUT_CYCLES`, 32'd1024, maximum WAIT_ACK cycles before `o_timeout` sets; 0 disables the timeout.
- `i_clk`  in  1  source-domain clock; all logic on posedge.
- `i_reset_n`  in  1  one clock; reset is synchronous and active-low.
- `i_valid`  in  1  local word available.
- `i_data`  in  WIDTH  local word, sampled on accept.
- `o_ready`  out  1  block can accept a word (state == IDLE).
- `o_req`  out  1  request toggle to destination domain, registered.
- `o_data`  out  WIDTH  held payload to destination domain, registered.
- `i_ack`  in  1  acknowledge toggle from destination domain, asynchronous.
- `o_done`  out  1  one-cycle pulse when a transfer completes.
- `o_timeout`  out  1  sticky: a WAIT_ACK exceeded TIMEOUT_CYCLES.
- `o_spurious_ack`  out  1  sticky: synchronized ack changed while IDLE.

## Operation
- Synchronizer: `ack_meta` <= `i_ack`; `ack_sync` <= `ack_meta`. Both reset to 0. Only `ack_sync` is used.
- FSM states:
  - IDLE: `o_ready` = 1.
    - On `i_valid` = 1: `o_data` <= `i_data`, `o_req` <= ~`o_req`, timeout counter <= 0, go to WAIT_ACK.
    - If `ack_sync` != `o_req` while IDLE: set `o_spurious_ack`. State, `o_req` and `o_data` are unaffected.
  - WAIT_ACK: `o_ready` = 0. `i_valid` and `i_data` are ignored.
    - When `ack_sync` == `o_req`: go to IDLE and pulse `o_done` for one cycle.
    - Otherwise the counter increments, saturating. When it reaches TIMEOUT_CYCLES-1 (if TIMEOUT_CYCLES ≠ 0), `o_timeout` <= 1.
    - The block stays in WAIT_ACK after a timeout. A request is never abandoned.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.
- `o_data` changes only on accept. It is stable from the `o_req` toggle until the next accept, so the destination may sample it after seeing the synchronized `o_req`.
- `o_req` toggles only on accept. There is exactly one toggle per word.
- Sticky flags clear only on reset.
- Reset values (while `i_reset_n` = 0 and the first cycle after): state IDLE, `o_ready` 1, `o_req` 0, `o_data` 0, `o_done` 0, `o_timeout` 0, `o_spurious_ack` 0, `ack_meta`/`ack_sync` 0, counter 0.
- Reset mid-WAIT_ACK: the block returns to IDLE and `o_req` returns to 0 immediately. The destination must be reset in the same reset event; otherwise `o_spurious_ack` may set.

## Timing
- Accept at edge E (IDLE, `i_valid` = 1): `o_req` toggled, `o_data` updated, `o_ready` = 0, all visible after E.
- Ack path: `i_ack` changes before edge A. `ack_meta` updates at A, `ack_sync` at A+1. The compare is registered at A+2: `o_ready` = 1 and `o_done` = 1 after A+2, and `o_done` = 0 after A+3.
- Minimum gap between accepts is 4 cycles: accept, then 3 cycles of synchronizer and compare, assuming `i_ack` toggles before the edge following the accept.
- Back-to-back: `i_valid` held high while `o_done` pulses is accepted at the next edge, because `o_ready` = 1 in that cycle.
- Simultaneous events: in the IDLE cycle after completion, accept and spurious-ack detection are evaluated independently on the pre-edge values.

## Test plan
- Reset: drive `i_reset_n` = 0 for 3 cycles with `i_valid` = 1 -> `o_req` = 0, `o_data` = 0, `o_ready` = 1, no accept; after release, first edge with `i_valid` accepts.
- Single transfer, WIDTH = 32: `i_data` = 0xDEADBEEF accepted -> `o_req` 0→1, `o_data` = 0xDEADBEEF; bench toggles `i_ack` to 1 one cycle later -> `o_done` pulses exactly 3 edges after the `i_ack` change, `o_ready` returns to 1.
- Busy ignore: during WAIT_ACK drive `i_data` = 0x12345678 with `i_valid` = 1 for 10 cycles -> `o_data` stays 0xDEADBEEF, `o_req` unchanged; 0x12345678 accepted only after `o_done`.
- Back-to-back: 8 words 0..7 with immediate ack toggles -> 8 `o_req` toggles, 8 `o_done` pulses, words in order, 4-cycle spacing.
- Timeout: TIMEOUT_CYCLES = 16, `i_ack` never toggles -> `o_timeout` = 1 after 16 WAIT_ACK cycles, `o_ready` stays 0; later ack toggle completes normally with `o_timeout` still 1.
- Spurious ack / reset mid-operation: toggle `i_ack` while IDLE -> `o_spurious_ack` = 1 three edges later, no state change; assert reset in WAIT_ACK -> `o_req` = 0, `o_ready` = 1, all flags cleared.
